disp_mux: RTL and testbench

Four-digit seven-segment scan driver. Sits directly downstream of heartbeat: consumes its four active-low segment patterns dig_0..dig_3 and time-multiplexes them onto the board's shared segment bus and per-digit active-low anodes. Snapshots the input digits once per scan frame so no digit tears mid-frame. Inserts a blanking gap at every digit switch to suppress ghosting.

---
 rtl/disp_pkg.sv | 21 ++
 rtl/disp_refresh_timer.sv | 51 +++++
 rtl/disp_mux.sv | 66 ++++++
 tb/tb_disp_mux.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared constants and helpers for the four-digit seven-segment scan driver.
package disp_pkg;

    localparam int          NUM_DIGITS = 4;
    localparam logic [7:0]  SEG_BLANK  = 8'hFF;
    localparam logic [3:0]  AN_OFF     = 4'b1111;

    // One-cold anode pattern that lights only the selected digit.
    function automatic logic [3:0] an_decode(input logic [1:0] sel);
        logic [3:0] an_v;
        case (sel)
            2'd0:    an_v = 4'b1110;
            2'd1:    an_v = 4'b1101;
            2'd2:    an_v = 4'b1011;
            2'd3:    an_v = 4'b0111;
            default: an_v = AN_OFF;
        endcase
        return an_v;
    endfunction

endpackage

// File: rtl/disp_refresh_timer.sv
// Slot counter and digit select for the scan driver; decodes blanking,
// slot-terminal and frame-boundary strobes from its own state.
module disp_refresh_timer
    import disp_pkg::*;
#(
    parameter int REFRESH_COUNT_MAX = 100000,
    parameter int BLANK_CYCLES      = 1000,
    parameter int CNT_WIDTH         = 17
) (
    input  logic       clk,
    input  logic       reset,
    output logic [1:0] sel,
    output logic       blank,
    output logic       terminal,
    output logic       frame_boundary
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(REFRESH_COUNT_MAX - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] BLANK_LIM = CNT_WIDTH'(BLANK_CYCLES);

    logic [CNT_WIDTH-1:0] cnt_r;
    logic [1:0]           sel_r;

    // Advance the slot counter; step to the next digit on the last cycle of a slot.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r <= '0;
            sel_r <= 2'd0;
        end else if (terminal) begin
            cnt_r <= '0;
            sel_r <= sel_r + 2'd1;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    assign sel            = sel_r;
    assign terminal       = (cnt_r == CNT_LAST);
    assign frame_boundary = terminal && (sel_r == 2'd3);

    // With no gap the compare would be against zero, so it is removed entirely.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign blank = 1'b0;
        end else begin : g_blank
            assign blank = (cnt_r < BLANK_LIM);
        end
    endgenerate

endmodule

// File: rtl/disp_mux.sv
// Four-digit seven-segment scan driver: per-frame digit snapshots, blanking
// gap at each digit switch, registered segment/anode/frame_tick outputs.
module disp_mux
    import disp_pkg::*;
#(
    parameter int REFRESH_COUNT_MAX = 100000,
    parameter int BLANK_CYCLES      = 1000,
    parameter int CNT_WIDTH         = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] dig_0,
    input  logic [7:0] dig_1,
    input  logic [7:0] dig_2,
    input  logic [7:0] dig_3,
    input  logic [3:0] digit_en,
    output logic [7:0] seg,
    output logic [3:0] an,
    output logic       frame_tick
);

    logic [1:0] sel_s;
    logic       blank_s;
    logic       terminal_s;
    logic       frame_boundary_s;

    logic [NUM_DIGITS-1:0][7:0] shadow_r;

    disp_refresh_timer #(
        .REFRESH_COUNT_MAX (REFRESH_COUNT_MAX),
        .BLANK_CYCLES      (BLANK_CYCLES),
        .CNT_WIDTH         (CNT_WIDTH)
    ) u_timer (
        .clk            (clk),
        .reset          (reset),
        .sel            (sel_s),
        .blank          (blank_s),
        .terminal       (terminal_s),
        .frame_boundary (frame_boundary_s)
    );

    // Snapshot digits at the frame boundary and drive the bus from pre-edge state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            shadow_r   <= {NUM_DIGITS{SEG_BLANK}};
            seg        <= SEG_BLANK;
            an         <= AN_OFF;
            frame_tick <= 1'b0;
        end else begin
            if (frame_boundary_s) begin
                shadow_r <= {dig_3, dig_2, dig_1, dig_0};
            end else begin
                shadow_r <= shadow_r;
            end
            if (blank_s || !digit_en[sel_s]) begin
                seg <= SEG_BLANK;
                an  <= AN_OFF;
            end else begin
                seg <= shadow_r[sel_s];
                an  <= an_decode(sel_s);
            end
            frame_tick <= frame_boundary_s;
        end
    end

endmodule

// File: tb/tb_disp_mux.sv
// Bench for disp_mux: a gapped build (8-cycle slots, 2 blank) and a gap-free
// build share stimulus and are compared against a cycle-index reference model.
module tb_disp_mux;

    localparam int R = 8;
    localparam int FRAME = 4 * R;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] dig_0 = 8'h00, dig_1 = 8'h00, dig_2 = 8'h00, dig_3 = 8'h00;
    logic [3:0] digit_en = 4'hF;

    logic [7:0] seg_a, seg_b;
    logic [3:0] an_a, an_b;
    logic       tick_a, tick_b;

    int total = 0;
    int bad = 0;

    // Model state: t counts edges since reset release, msh holds snapshots.
    int         t = 0;
    logic [7:0] msh [4];
    logic [7:0] exp_seg_a, exp_seg_b;
    logic [3:0] exp_an_a, exp_an_b;
    logic       exp_tick;

    always #5 clk = ~clk;

    disp_mux #(.REFRESH_COUNT_MAX(R), .BLANK_CYCLES(2), .CNT_WIDTH(3)) u_dut_a (
        .clk(clk), .reset(reset), .dig_0(dig_0), .dig_1(dig_1), .dig_2(dig_2),
        .dig_3(dig_3), .digit_en(digit_en), .seg(seg_a), .an(an_a), .frame_tick(tick_a)
    );

    disp_mux #(.REFRESH_COUNT_MAX(R), .BLANK_CYCLES(0), .CNT_WIDTH(3)) u_dut_b (
        .clk(clk), .reset(reset), .dig_0(dig_0), .dig_1(dig_1), .dig_2(dig_2),
        .dig_3(dig_3), .digit_en(digit_en), .seg(seg_b), .an(an_b), .frame_tick(tick_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%0h expected=%0h (t=%0d)", tag, got, want, t);
        end
    endtask

    // Predict the outputs of the coming edge, advance the model, then check.
    task automatic step();
        int         cnt;
        int         slot;
        logic [3:0] onehot;
        if (!reset) begin
            exp_seg_a = 8'hFF; exp_seg_b = 8'hFF;
            exp_an_a  = 4'hF;  exp_an_b  = 4'hF;
            exp_tick  = 1'b0;
            t = 0;
            for (int i = 0; i < 4; i++) msh[i] = 8'hFF;
        end else begin
            cnt    = t % R;
            slot   = (t / R) % 4;
            onehot = 4'b0001 << slot;
            if (cnt >= 2 && digit_en[slot]) begin
                exp_seg_a = msh[slot]; exp_an_a = ~onehot;
            end else begin
                exp_seg_a = 8'hFF;     exp_an_a = 4'hF;
            end
            if (digit_en[slot]) begin
                exp_seg_b = msh[slot]; exp_an_b = ~onehot;
            end else begin
                exp_seg_b = 8'hFF;     exp_an_b = 4'hF;
            end
            exp_tick = ((t % FRAME) == FRAME - 1);
            if (exp_tick) begin
                msh[0] = dig_0; msh[1] = dig_1; msh[2] = dig_2; msh[3] = dig_3;
            end
            t++;
        end
        @(posedge clk);
        #1;
        chk("seg_a", 32'(seg_a), 32'(exp_seg_a));
        chk("an_a", 32'(an_a), 32'(exp_an_a));
        chk("tick_a", 32'(tick_a), 32'(exp_tick));
        chk("seg_b", 32'(seg_b), 32'(exp_seg_b));
        chk("an_b", 32'(an_b), 32'(exp_an_b));
        chk("tick_b", 32'(tick_b), 32'(exp_tick));
        chk("onecold_a", 32'($countones(~an_a) <= 1), 32'd1);
        chk("onecold_b", 32'($countones(~an_b) <= 1), 32'd1);
    endtask

    initial begin
        int hit;

        // Reset held for three cycles.
        reset = 1'b0;
        dig_0 = 8'($urandom); dig_1 = 8'($urandom); dig_2 = 8'($urandom); dig_3 = 8'($urandom);
        for (int i = 0; i < 3; i++) step();

        // First frame is blank; tick on its last edge.
        reset = 1'b1;
        dig_0 = 8'hC0; dig_1 = 8'hF9; dig_2 = 8'hA4; dig_3 = 8'hB0;
        for (int i = 0; i < FRAME; i++) step();

        // Second frame; dig_1 changes during slot 2 but must not show until frame 3.
        for (int i = 0; i < 2 * R + 3; i++) step();
        dig_1 = 8'h99;
        for (int i = 0; i < 2 * R - 3; i++) step();
        for (int i = 0; i < FRAME; i++) step();
        chk("seen_99", 32'(msh[1]), 32'h99);

        // Digit 2 disabled for two frames.
        digit_en = 4'b1011;
        for (int i = 0; i < 2 * FRAME; i++) step();
        digit_en = 4'hF;

        // Reset for one cycle while digit 2 is lit, then time the next tick.
        dig_0 = 8'($urandom); dig_2 = 8'($urandom);
        for (int i = 0; i < FRAME && !(((t % FRAME) / R) == 2 && (t % R) >= 4); i++) step();
        reset = 1'b0;
        step();
        chk("rst_an_a", 32'(an_a), 32'hF);
        chk("rst_seg_a", 32'(seg_a), 32'hFF);
        reset = 1'b1;
        hit = -1;
        for (int i = 0; i < FRAME + 8; i++) begin
            step();
            if (tick_a && hit < 0) hit = i;
        end
        chk("tick_after_reset", 32'(hit), 32'(FRAME - 1));

        // Randomized inputs, enable changes and occasional resets.
        for (int i = 0; i < 320; i++) begin
            dig_0 = 8'($urandom); dig_1 = 8'($urandom);
            dig_2 = 8'($urandom); dig_3 = 8'($urandom);
            if ($urandom_range(0, 15) == 0) digit_en = 4'($urandom_range(0, 15));
            reset = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
